cpu6_memarb: RTL
================

Name: cpu6_memarb

Overview:
- Arbitrates the core's instruction-fetch port and data-access port onto one shared single-port memory bus.
- Allows one outstanding transaction at a time.
- Data accesses have priority over fetch. A starvation counter guarantees fetch progress.
- Sits between cpu6_core (fetch and load/store sides) and the unified memory.

Parameters:
- XLEN, 32: address and data width; matches CPU6_XLEN.
- STARVE_MAX, 4: number of consecutive data grants allowed while fetch waits before fetch is forced; range 1..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  XLEN  fetch address.
- if_gnt  out  1  one-cycle pulse; fetch request accepted and latched.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  XLEN  fetched instruction.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  write data.
- d_gnt  out  1  one-cycle pulse; data request latched.
- d_rvalid  out  1  one-cycle pulse; read data valid, or write complete.
- d_rdata  out  XLEN  load data; 0 for writes.
- mem_req  out  1  request to memory; held until mem_gnt.
- mem_we, mem_addr, mem_wdata  out  1/XLEN/XLEN  latched command fields.
- mem_gnt  in  1  memory accepted the command this cycle.
- mem_rvalid  in  1  response or write-ack; arrives at least one cycle after mem_gnt.
- mem_rdata  in  XLEN  response data.

Behaviour:

Reset (reset = 0, asynchronous):
- State = IDLE, owner = NONE, starve counter = 0.
- All outputs 0, including data buses.

States and transitions:
- IDLE:
  - No request: remain in IDLE.
  - d_req and fetch not forced: d_gnt = 1 this cycle; latch d_we/d_addr/d_wdata; owner = D; go to ISSUE.
  - if_req and (no d_req, or starve counter == STARVE_MAX): if_gnt = 1; latch if_addr with we = 0; owner = IF; go to ISSUE.
  - gnt is combinational from req in IDLE. Grant to memory-issue latency is 1 cycle.
- ISSUE:
  - mem_req = 1 with latched fields.
  - On mem_gnt: go to WAIT; mem_req drops the next cycle.
- WAIT:
  - mem_req = 0.
  - On mem_rvalid: the owner's rvalid pulses in the same cycle. rdata is mem_rdata (0 for a write). Go to IDLE, owner = NONE.
  - mem_rvalid and mem_gnt in the same ISSUE cycle is illegal.

Rules:
- mem_rvalid in IDLE or ISSUE is ignored. It produces no rvalid pulse.
- Requester gnt is never asserted outside IDLE. A req that rises mid-transaction waits.
- Starve counter, updated on each grant:
  - Data grant while if_req = 1: increment, saturating at STARVE_MAX.
  - Fetch grant: clear to 0.
  - Data grant while if_req = 0: clear to 0.
- Simultaneous requests: data wins unless the counter equals STARVE_MAX.
- Reset mid-transaction: owner is discarded, no rvalid is produced, and a later stale mem_rvalid is ignored in IDLE. The memory must also be reset by the same reset.
- Throughput: at most one transaction per 3 cycles (IDLE, ISSUE, WAIT, each with minimum 1-cycle memory latency).
- Unused rdata output is 0 when its rvalid is 0.

Decomposition:
- defines.v:
  - CPU6_MEMARB_STATE_SIZE with IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2.
  - CPU6_MEMARB_OWNER_NONE/IF/D as 2-bit codes.
  - CPU6_MEMARB_STARVE_SIZE = 4.
  - Reuse CPU6_XLEN.
- State and command registers use cpu6_dfflr-style flops with an asynchronous active-low clear.
- One sub-module: cpu6_memarb_starve, holding the saturating counter and the force_if output.

Test Plan:
- Single fetch: if_req = 1, addr 0x100 at cycle 0, no d_req.
  - Expect if_gnt at cycle 0, mem_req cycles 1..k until mem_gnt.
  - Memory returns 0xDEADBEEF 2 cycles later; if_rvalid pulse with if_rdata = 0xDEADBEEF; d_rvalid stays 0.
- Simultaneous requests: if_req (0x200) and d_req read (0x1000) in the same cycle.
  - Expect d_gnt first and mem_addr = 0x1000.
  - After d_rvalid, if_gnt in the next IDLE cycle with mem_addr = 0x200.
- Starvation, STARVE_MAX = 4: if_req held, d_req held continuously.
  - Expect exactly 4 d_gnt, then an if_gnt, then data resumes.
  - Counter reads 0 after the fetch grant.
- Data write: d_we = 1, addr 0x40, wdata 0x12345678.
  - Expect mem_we = 1 with the same addr/data.
  - On mem_rvalid, d_rvalid pulses with d_rdata = 0.
- Stall and stray: mem_gnt held low for 5 cycles, then pulses.
  - mem_req stays 1 for all 6 cycles with stable fields.
  - A stray mem_rvalid injected in IDLE produces no rvalid.
- Reset mid-WAIT: assert reset = 0 asynchronously.
  - All outputs go to 0 immediately.
  - A late mem_rvalid after release produces no rvalid; a fresh if_req is granted normally.

Source files
------------

// File: rtl/cpu6_memarb_pkg.sv
// Shared constants and encodings for the cpu6 fetch/data memory arbiter.
package cpu6_memarb_pkg;

    localparam int CPU6_XLEN               = 32;
    localparam int CPU6_MEMARB_STARVE_SIZE = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } memarb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } memarb_owner_e;

endpackage

// File: rtl/cpu6_memarb_starve.sv
// Counts consecutive data grants taken while fetch is waiting; forces a fetch
// grant once the count reaches STARVE_MAX.
module cpu6_memarb_starve
    import cpu6_memarb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req_i,
    input  logic d_grant_i,
    input  logic if_grant_i,
    output logic force_if_o
);

    localparam int W = CPU6_MEMARB_STARVE_SIZE;
    localparam logic [W-1:0] MAX_C = W'(STARVE_MAX);
    localparam logic [W-1:0] ONE_C = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (if_grant_i) begin
            cnt_d = '0;
        end else if (d_grant_i) begin
            if (!if_req_i)
                cnt_d = '0;
            else if (cnt_q != MAX_C)
                cnt_d = cnt_q + ONE_C;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Only meaningful while fetch is actually waiting.
    assign force_if_o = if_req_i && (cnt_q == MAX_C);

endmodule

// File: rtl/cpu6_memarb.sv
// Single-outstanding arbiter of the core's fetch and data ports onto one
// shared memory bus; data has priority, bounded by the starvation counter.
module cpu6_memarb
    import cpu6_memarb_pkg::*;
#(
    parameter int XLEN       = CPU6_XLEN,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    memarb_state_e   state_q;
    memarb_owner_e   owner_q;
    logic            mem_req_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;

    logic idle_ok, force_if, d_take, if_take, rsp;

    // Gating with reset keeps the combinational grants low while reset is held.
    assign idle_ok = reset && (state_q == ST_IDLE);
    assign d_take  = idle_ok && d_req && !force_if;
    assign if_take = idle_ok && if_req && !d_take;

    cpu6_memarb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk        (clk),
        .reset      (reset),
        .if_req_i   (if_req),
        .d_grant_i  (d_take),
        .if_grant_i (if_take),
        .force_if_o (force_if)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            mem_req_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (d_take) begin
                        we_q      <= d_we;
                        addr_q    <= d_addr;
                        wdata_q   <= d_wdata;
                        owner_q   <= OWN_D;
                        mem_req_q <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end else if (if_take) begin
                        we_q      <= 1'b0;
                        addr_q    <= if_addr;
                        wdata_q   <= '0;
                        owner_q   <= OWN_IF;
                        mem_req_q <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        owner_q <= OWN_NONE;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    owner_q   <= OWN_NONE;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    // Responses outside WAIT (stale or stray) are dropped here.
    assign rsp       = (state_q == ST_WAIT) && mem_rvalid;
    assign if_rvalid = rsp && (owner_q == OWN_IF);
    assign d_rvalid  = rsp && (owner_q == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;

    assign if_gnt    = if_take;
    assign d_gnt     = d_take;
    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
